// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one imem read at a time, holds the returned
// word for decode and handles branch redirects, halt and memory timeouts.
module instr_fetch #(
  parameter logic [15:0] PC_RST   = 16'h0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_ack,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        halt,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [1:0]  ir_cls,
  output logic [13:0] ir_pay,
  output logic        fetch_err
);

  typedef enum logic [2:0] {FETCH, WAIT, HOLD, DRAIN, STOP} state_t;

  localparam int TW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(MAX_WAIT - 1);

  state_t        state_reg, state_next;
  logic [15:0]   pc_reg, pc_next;
  logic [15:0]   ir_reg, ir_next;
  logic [15:0]   ir_pc_reg, ir_pc_next;
  logic          ir_valid_reg, ir_valid_next;
  logic          rd_reg, rd_next;
  logic [15:0]   addr_reg, addr_next;
  logic          err_reg, err_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          tmo_hit;

  assign tmo_hit = (tmo_reg == TMO_LAST);

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_pc_next    = ir_pc_reg;
    ir_valid_next = ir_valid_reg;
    rd_next       = 1'b0;
    addr_next     = addr_reg;
    err_next      = err_reg;
    tmo_next      = tmo_reg;
    case (state_reg)
      FETCH: begin
        if (br_taken) begin
          pc_next       = br_target;
          ir_valid_next = 1'b0;
        end else if (halt || err_reg) begin
          state_next = STOP;
        end else begin
          rd_next    = 1'b1;
          addr_next  = pc_reg;
          tmo_next   = '0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          tmo_next = '0;
          if (br_taken) begin
            // Redirect wins over the returning word, which is dropped.
            pc_next    = br_target;
            state_next = FETCH;
          end else begin
            ir_next       = imem_data;
            ir_pc_next    = pc_reg;
            pc_next       = pc_reg + 16'd1;
            ir_valid_next = 1'b1;
            state_next    = HOLD;
          end
        end else begin
          if (br_taken) pc_next = br_target;
          if (tmo_hit) begin
            err_next   = 1'b1;
            state_next = STOP;
          end else begin
            tmo_next   = tmo_reg + TW'(1);
            state_next = br_taken ? DRAIN : WAIT;
          end
        end
      end
      DRAIN: begin
        if (br_taken) pc_next = br_target;
        if (imem_ack) begin
          tmo_next   = '0;
          state_next = FETCH;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = STOP;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
      HOLD: begin
        if (br_taken) begin
          pc_next       = br_target;
          ir_valid_next = 1'b0;
          state_next    = FETCH;
        end else if (ir_ready) begin
          ir_valid_next = 1'b0;
          state_next    = FETCH;
        end
      end
      STOP: begin
        if (br_taken) pc_next = br_target;
        if (!err_reg && !halt) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      pc_reg       <= PC_RST;
      ir_reg       <= 16'h0000;
      ir_pc_reg    <= 16'h0000;
      ir_valid_reg <= 1'b0;
      rd_reg       <= 1'b0;
      addr_reg     <= PC_RST;
      err_reg      <= 1'b0;
      tmo_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_pc_reg    <= ir_pc_next;
      ir_valid_reg <= ir_valid_next;
      rd_reg       <= rd_next;
      addr_reg     <= addr_next;
      err_reg      <= err_next;
      tmo_reg      <= tmo_next;
    end
  end

  assign imem_addr = addr_reg;
  assign imem_rd   = rd_reg;
  assign ir        = ir_reg;
  assign ir_pc     = ir_pc_reg;
  assign ir_valid  = ir_valid_reg;
  assign ir_cls    = ir_reg[15:14];
  assign ir_pay    = ir_reg[13:0];
  assign fetch_err = err_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: behavioural memory, scoreboard of expected
// decode-side words, immediate assertions at every check point.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_ack;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic        halt = 1'b0;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready = 1'b1;
  logic [1:0]  ir_cls;
  logic [13:0] ir_pay;
  logic        fetch_err;

  logic        mem_ack = 1'b0;
  logic        extra_ack = 1'b0;
  logic        mem_en = 1'b1;
  int          lat = 1;
  logic [15:0] mem [0:65535];

  assign imem_ack = mem_ack | extra_ack;

  instr_fetch #(.PC_RST(16'h0000), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rd(imem_rd),
    .imem_data(imem_data), .imem_ack(imem_ack),
    .br_taken(br_taken), .br_target(br_target), .halt(halt),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_cls(ir_cls), .ir_pay(ir_pay), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   acc_cnt = 0;
  int   req_cnt = 0;
  int   cyc = 0;
  int   acc_cyc[$];
  logic saw_1234 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: lat=1 presents ack in the cycle right after the issuing edge.
  initial begin
    logic [15:0] a;
    imem_data = 16'h0000;
    forever begin
      @(posedge clk); #1;
      if (imem_rd && mem_en) begin
        a = imem_addr;
        repeat (lat - 1) begin @(posedge clk); #1; end
        imem_data = mem[a];
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
      end
    end
  end

  always @(posedge clk) cyc++;

  // Decode side: every accepted word is popped from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (imem_rd) req_cnt++;
    if (ir_valid && ir == 16'h1234) saw_1234 = 1'b1;
    if (rst_n && ir_valid && ir_ready) begin
      chk("sb_has_entry", {31'b0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ir", {16'b0, ir}, {16'b0, e.w});
        chk("ir_pc", {16'b0, ir_pc}, {16'b0, e.pc});
        chk("ir_cls", {30'b0, ir_cls}, {30'b0, e.w[15:14]});
        chk("ir_pay", {18'b0, ir_pay}, {18'b0, e.w[13:0]});
        $display("accept ir=%h ir_pc=%h cycle=%0d", ir, ir_pc, cyc);
      end
      acc_cnt++;
      acc_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] a);
    exp_q.push_back('{mem[a], a});
  endtask

  task automatic wait_req(input string tag, input logic [15:0] exp_addr);
    int k = 0;
    tick();
    while (!imem_rd && k < 60) begin tick(); k++; end
    chk({tag, "_req_seen"}, {31'b0, imem_rd}, 32'd1);
    chk({tag, "_addr"}, {16'b0, imem_addr}, {16'b0, exp_addr});
    $display("request %s addr=%h cycle=%0d", tag, imem_addr, cyc);
  endtask

  task automatic wait_acc(input string tag, input int n);
    int k = 0;
    while (acc_cnt < n && k < 60) begin tick(); k++; end
    chk({tag, "_acc_count"}, 32'(acc_cnt), 32'(n));
  endtask

  initial begin
    int k;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h3C00;
    mem[0] = 16'hA000; mem[1] = 16'hB001; mem[2] = 16'hC002;
    mem[5] = 16'h1234;

    // Reset state
    tick(); tick();
    chk("rst_rd", {31'b0, imem_rd}, 32'd0);
    chk("rst_addr", {16'b0, imem_addr}, 32'h0000);
    chk("rst_ir", {16'b0, ir}, 32'h0000);
    chk("rst_ir_pc", {16'b0, ir_pc}, 32'h0000);
    chk("rst_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    // Streaming with ir_ready tied high
    push(16'h0000); push(16'h0001); push(16'h0002);
    rst_n = 1'b1;
    tick();
    chk("first_rd", {31'b0, imem_rd}, 32'd1);
    chk("first_addr", {16'b0, imem_addr}, 32'h0000);
    k = 0;
    while (!ir_valid && k < 20) begin tick(); k++; end
    chk("first_cls", {30'b0, ir_cls}, 32'd2);
    chk("first_pay", {18'b0, ir_pay}, 32'h2000);
    k = 0;
    while (!(imem_rd && imem_addr == 16'h0002) && k < 20) begin tick(); k++; end
    halt = 1'b1;
    wait_acc("stream", 3);
    if (acc_cyc.size() >= 3) begin
      chk("gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      chk("gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    end

    // Decode stall
    ir_ready = 1'b0;
    push(16'h0003);
    halt = 1'b0;
    k = 0;
    while (!ir_valid && k < 20) begin tick(); k++; end
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ir", {16'b0, ir}, {16'b0, mem[3]});
      chk("stall_ir_pc", {16'b0, ir_pc}, 32'h0003);
      chk("stall_valid", {31'b0, ir_valid}, 32'd1);
      chk("stall_no_rd", {31'b0, imem_rd}, 32'd0);
    end
    halt = 1'b0;
    push(16'h0004);
    ir_ready = 1'b1;
    tick();
    chk("post_acc_rd", {31'b0, imem_rd}, 32'd0);
    chk("post_acc_valid", {31'b0, ir_valid}, 32'd0);
    tick();
    chk("resume_rd", {31'b0, imem_rd}, 32'd1);
    chk("resume_addr", {16'b0, imem_addr}, 32'h0004);
    halt = 1'b1;
    wait_acc("stall", 5);

    // Branch while waiting, late ack carries 0x1234
    lat = 4;
    halt = 1'b0;
    wait_req("br_wait", 16'h0005);
    br_taken = 1'b1; br_target = 16'h0040;
    push(16'h0040);
    tick();
    br_taken = 1'b0; lat = 1;
    wait_req("after_drain", 16'h0040);
    halt = 1'b1;
    wait_acc("drain", 6);

    // Branch in the same cycle as ack
    halt = 1'b0;
    wait_req("br_ack", 16'h0041);
    br_taken = 1'b1; br_target = 16'h0080;
    push(16'h0080);
    tick();
    br_taken = 1'b0;
    chk("br_ack_valid", {31'b0, ir_valid}, 32'd0);
    wait_req("after_br_ack", 16'h0080);
    chk("br_ack_valid2", {31'b0, ir_valid}, 32'd0);
    halt = 1'b1;
    wait_acc("br_ack", 7);

    // Redirect while stopped, then pc wrap
    tick();
    br_taken = 1'b1; br_target = 16'hFFFF;
    tick();
    br_taken = 1'b0;
    tick();
    chk("stop_no_rd", {31'b0, imem_rd}, 32'd0);
    push(16'hFFFF); push(16'h0000);
    halt = 1'b0;
    wait_req("wrap_ffff", 16'hFFFF);
    wait_req("wrap_0000", 16'h0000);
    halt = 1'b1;
    wait_acc("wrap", 9);

    // Timeout
    mem_en = 1'b0;
    halt = 1'b0;
    wait_req("tmo", 16'h0001);
    k = 0;
    while (!fetch_err && k < 40) begin tick(); k++; end
    chk("tmo_cycles", 32'(k), 32'd15);
    k = req_cnt;
    repeat (20) tick();
    chk("tmo_no_rd", 32'(req_cnt), 32'(k));
    chk("tmo_err_sticky", {31'b0, fetch_err}, 32'd1);

    // Reset clears the error and restarts at PC_RST
    rst_n = 1'b0;
    #1;
    chk("arst_err", {31'b0, fetch_err}, 32'd0);
    chk("arst_rd", {31'b0, imem_rd}, 32'd0);
    chk("arst_addr", {16'b0, imem_addr}, 32'h0000);
    mem_en = 1'b1;
    push(16'h0000);
    tick(); tick();
    rst_n = 1'b1;
    extra_ack = 1'b1;
    tick();
    extra_ack = 1'b0;
    chk("restart_rd", {31'b0, imem_rd}, 32'd1);
    chk("restart_addr", {16'b0, imem_addr}, 32'h0000);
    halt = 1'b1;
    wait_acc("restart", 10);

    repeat (3) tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("no_1234", {31'b0, saw_1234}, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
